full_adder: RTL and testbench

- Parameterised ripple-carry adder.
- WIDTH=1 gives the classic 1-bit full adder: sum = a^b^cin, cout = majority(a,b,cin).
- Combinational sum/cout for direct use in ALU datapaths.
- A registered copy with valid and overflow flags feeds the clocked ALU result stage.

---
 rtl/full_adder_pkg.sv | 13 +
 rtl/full_adder_fa_cell.sv | 22 ++
 rtl/full_adder.sv | 85 ++++++++
 tb/tb_full_adder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared helpers for the ripple-carry adder
//
// Purpose: the single-bit carry function, kept in one place so the adder
// cell has only one definition of the carry rule.
// Ports: none (package).
package full_adder_pkg;

  // Majority of three inputs: the carry out of one full-adder bit.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// rtl/full_adder_fa_cell.sv - 1-bit full adder cell
//
// Purpose: one bit of the ripple-carry chain.
// Ports:
//   a, b  : operand bits
//   cin   : carry into this bit
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
module fa_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - parameterised ripple-carry adder with registered result stage
//
// Purpose: combinational WIDTH-bit adder plus an optional one-cycle
// registered copy of sum/carry/signed-overflow with a valid flag.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   a, b      : WIDTH-bit operands
//   cin       : carry in
//   in_valid  : qualifies a/b/cin for the registered path
//   sum, cout : combinational result, zero latency
//   sum_q, cout_q, ovf_q, valid_q : registered result (constant 0 if REG_OUT=0)
module full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             valid_q
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out.
  logic [WIDTH:0] c;
  logic           ovf;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_chain
      fa_cell u_cell (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (c[i]),
        .sum  (sum[i]),
        .cout (c[i+1])
      );
    end
  endgenerate

  assign cout = c[WIDTH];

  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH=1 the carry into the sign bit is cin itself.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q   <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= in_valid;
          // Result registers only move on a qualified operation.
          if (in_valid) begin
            sum_q  <= sum;
            cout_q <= cout;
            ovf_q  <= ovf;
          end
        end
      end
    end else begin : g_noreg
      // Clock/reset/valid have no load in this configuration.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, in_valid, ovf};

      assign sum_q   = '0;
      assign cout_q  = 1'b0;
      assign ovf_q   = 1'b0;
      assign valid_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed and random bench for full_adder
`timescale 1ns/100ps
module tb_full_adder;

  logic clk, rst, in_valid;

  logic        a1, b1, cin1, sum1, cout1, sum1_q, cout1_q, ovf1_q, valid1_q;
  logic [7:0]  a8, b8, sum8, sum8_q;
  logic        cin8, cout8, cout8_q, ovf8_q, valid8_q;
  logic [31:0] a32, b32, sum32, sum32_q;
  logic        cin32, cout32, cout32_q, ovf32_q, valid32_q;
  logic [7:0]  sumn, sumn_q;
  logic        coutn, coutn_q, ovfn_q, validn_q;

  int checks = 0;
  int failures = 0;

  full_adder #(.WIDTH(1), .REG_OUT(1)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(in_valid),
    .sum(sum1), .cout(cout1), .sum_q(sum1_q), .cout_q(cout1_q),
    .ovf_q(ovf1_q), .valid_q(valid1_q));

  full_adder #(.WIDTH(8), .REG_OUT(1)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(in_valid),
    .sum(sum8), .cout(cout8), .sum_q(sum8_q), .cout_q(cout8_q),
    .ovf_q(ovf8_q), .valid_q(valid8_q));

  full_adder #(.WIDTH(32), .REG_OUT(1)) u32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .in_valid(in_valid),
    .sum(sum32), .cout(cout32), .sum_q(sum32_q), .cout_q(cout32_q),
    .ovf_q(ovf32_q), .valid_q(valid32_q));

  full_adder #(.WIDTH(8), .REG_OUT(0)) un (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(in_valid),
    .sum(sumn), .cout(coutn), .sum_q(sumn_q), .cout_q(coutn_q),
    .ovf_q(ovfn_q), .valid_q(validn_q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (x & m) + (y & m) + {63'd0, ci};
  endfunction

  // Signed overflow from the arithmetic definition: true sum out of range.
  function automatic logic ref_ovf(input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input int w);
    longint sx, sy, s, lim;
    lim = longint'(1) << w;
    sx = longint'(x & 64'(lim - 1));
    sy = longint'(y & 64'(lim - 1));
    if (x[w-1]) sx = sx - lim;
    if (y[w-1]) sy = sy - lim;
    s = sx + sy + longint'(ci);
    return (s > (lim / 2 - 1)) || (s < -(lim / 2));
  endfunction

  task automatic chk_noreg(input string nm);
    chk({nm, "_noreg_q"}, {52'd0, sumn_q, coutn_q, ovfn_q, validn_q}, 64'd0);
  endtask

  typedef struct {
    logic [2:0] abc;
    logic       s;
    logic       co;
  } v1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } v8_t;

  v1_t v1 [8];
  v8_t v8 [7];

  logic [63:0] e1_s, e8_s, e32_s, r;
  logic        e1_c, e8_c, e32_c, e1_o, e8_o, e32_o, ev, iv;

  initial begin
    v1[0] = '{3'b000, 1'b0, 1'b0};
    v1[1] = '{3'b001, 1'b1, 1'b0};
    v1[2] = '{3'b010, 1'b1, 1'b0};
    v1[3] = '{3'b011, 1'b0, 1'b1};
    v1[4] = '{3'b100, 1'b1, 1'b0};
    v1[5] = '{3'b101, 1'b0, 1'b1};
    v1[6] = '{3'b110, 1'b0, 1'b1};
    v1[7] = '{3'b111, 1'b1, 1'b1};

    v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    v8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    v8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v8[5] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0; a8 = 0; b8 = 0; cin8 = 0; a32 = 0; b32 = 0; cin32 = 0;

    // Reset state
    #3;
    chk("rst_w1_q",  {60'd0, sum1_q, cout1_q, ovf1_q, valid1_q}, 64'd0);
    chk("rst_w8_q",  {52'd0, sum8_q, cout8_q, ovf8_q, valid8_q}, 64'd0);
    chk("rst_w32_q", {28'd0, sum32_q, cout32_q, ovf32_q, valid32_q}, 64'd0);
    chk_noreg("rst");

    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 exhaustive, no clock edge in between
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = v1[i].abc;
      #0.1;
      chk($sformatf("w1_vec%0d_sumcout", i), {62'd0, sum1, cout1}, {62'd0, v1[i].s, v1[i].co});
    end

    // WIDTH=8 table through comb and registered paths
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a8 = v8[i].a; b8 = v8[i].b; cin8 = v8[i].ci; in_valid = 1'b1;
      #1;
      chk($sformatf("w8_vec%0d_comb", i), {55'd0, cout8, sum8}, {55'd0, v8[i].co, v8[i].s});
      @(posedge clk); #1;
      chk($sformatf("w8_vec%0d_reg", i), {53'd0, sum8_q, cout8_q, ovf8_q, valid8_q},
          {53'd0, v8[i].s, v8[i].co, v8[i].ov, 1'b1});
    end
    chk_noreg("after_table");

    // Registered latency and hold
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("lat_sum_q", {56'd0, sum8_q}, 64'h47);
    chk("lat_cout_valid", {62'd0, cout8_q, valid8_q}, 64'b01);
    @(negedge clk);
    in_valid = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clk); #1;
    chk("hold_valid_q", {63'd0, valid8_q}, 64'd0);
    chk("hold_sum_q", {56'd0, sum8_q}, 64'h47);

    // Asynchronous reset between edges
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_valid_q", {63'd0, valid8_q}, 64'd1);
    #2;
    rst = 1'b1;
    #0.5;
    chk("arst_w8_q", {52'd0, sum8_q, cout8_q, ovf8_q, valid8_q}, 64'd0);
    chk("arst_w32_q", {28'd0, sum32_q, cout32_q, ovf32_q, valid32_q}, 64'd0);
    chk("arst_comb", {55'd0, cout8, sum8}, {55'd0, 1'b0, 8'h47});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_capture", {54'd0, sum8_q, cout8_q, valid8_q}, {54'd0, 8'h47, 1'b0, 1'b1});
    chk_noreg("post_rst");

    // Random regression at all three widths with a 1-cycle register model
    e1_s = 0; e8_s = 0; e32_s = 0; e1_c = 0; e8_c = 0; e32_c = 0;
    e1_o = 0; e8_o = 0; e32_o = 0; ev = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1));
      iv = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = iv;
      #1;
      r = ref_add({63'd0, a1}, {63'd0, b1}, cin1, 1);
      chk("rnd_w1_comb", {62'd0, cout1, sum1}, r);
      if (iv) begin e1_s = {63'd0, r[0]}; e1_c = r[1]; e1_o = ref_ovf({63'd0, a1}, {63'd0, b1}, cin1, 1); end
      r = ref_add({56'd0, a8}, {56'd0, b8}, cin8, 8);
      chk("rnd_w8_comb", {55'd0, cout8, sum8}, r);
      if (iv) begin e8_s = {56'd0, r[7:0]}; e8_c = r[8]; e8_o = ref_ovf({56'd0, a8}, {56'd0, b8}, cin8, 8); end
      r = ref_add({32'd0, a32}, {32'd0, b32}, cin32, 32);
      chk("rnd_w32_comb", {31'd0, cout32, sum32}, r);
      if (iv) begin e32_s = {32'd0, r[31:0]}; e32_c = r[32]; e32_o = ref_ovf({32'd0, a32}, {32'd0, b32}, cin32, 32); end
      ev = iv;
      @(posedge clk); #1;
      chk("rnd_w1_reg", {60'd0, sum1_q, cout1_q, ovf1_q, valid1_q}, {60'd0, e1_s[0], e1_c, e1_o, ev});
      chk("rnd_w8_reg", {52'd0, sum8_q, cout8_q, ovf8_q, valid8_q}, {52'd0, e8_s[7:0], e8_c, e8_o, ev});
      chk("rnd_w32_reg", {28'd0, sum32_q, cout32_q, ovf32_q, valid32_q}, {28'd0, e32_s[31:0], e32_c, e32_o, ev});
    end
    chk_noreg("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
